// File: rtl/run_detect_pkg.sv
// Shared types and helpers for the run-of-four detector arbiter.
// The requester index width is sized for the largest supported NREQ.
package run_detect_pkg;

    localparam int NREQ_MAX = 8;
    localparam int IDX_W    = $clog2(NREQ_MAX);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        STREAM,
        DRAIN,
        REPORT
    } state_t;

    // First set request searching upward from last+1 with wrap at n.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [NREQ_MAX-1:0] r,
        input logic [IDX_W-1:0]    last,
        input int                  n
    );
        logic [IDX_W-1:0] res;
        logic             found;
        int               idx;
        res   = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ_MAX; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !found && r[idx[IDX_W-1:0]]) begin
                res   = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/run_detect_arbiter_if.sv
// Requester/result bundle between the bit sources, the arbiter and the consumer.
// master = source/consumer side, slave = arbiter side.
interface run_detect_arbiter_if #(
    parameter int NREQ = 4,
    parameter int HW   = 5
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         bit_in;
    logic [NREQ-1:0]         bit_valid;
    logic [NREQ-1:0]         bit_ready;
    logic                    done;
    logic [$clog2(NREQ)-1:0] done_id;
    logic [HW-1:0]           hit_count;
    logic                    abort;

    modport master (
        output req, bit_in, bit_valid,
        input  gnt, bit_ready, done, done_id, hit_count, abort
    );

    modport slave (
        input  req, bit_in, bit_valid,
        output gnt, bit_ready, done, done_id, hit_count, abort
    );
endinterface

// File: rtl/run4_detector.sv
// Run-of-four detector: hit pulses the cycle after the 4th identical accepted bit.
// Context only advances on en; clear restores the post-reset context.
module run4_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic b,
    output logic hit
);
    logic prev, first, q0, q1, z;
    logic a;

    assign a   = first ? 1'b0 : (b == prev);
    assign hit = z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            first <= 1'b1;
            q0    <= 1'b0;
            q1    <= 1'b0;
            z     <= 1'b0;
        end else if (clear) begin
            prev  <= 1'b0;
            first <= 1'b1;
            q0    <= 1'b0;
            q1    <= 1'b0;
            z     <= 1'b0;
        end else if (en) begin
            prev  <= b;
            first <= 1'b0;
            q0    <= a;
            q1    <= a & q0;
            z     <= a & q1;
        end else begin
            z     <= 1'b0;
        end
    end
endmodule

// File: rtl/run_detect_arbiter.sv
// Round-robin share of one run-of-four detector; counts hits over BURST_LEN bits per grant.
// Optional stall timeout enabled by RUN_DET_TIMEOUT_EN.
module run_detect_arbiter
    import run_detect_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 16,
    parameter int HW        = $clog2(BURST_LEN + 1),
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    run_detect_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    if (NREQ < 2 || NREQ > NREQ_MAX || BURST_LEN < 4 || TIMEOUT < 1) begin : g_bad_cfg
        $error("run_detect_arbiter: unsupported parameter set");
    end

    state_t          state;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   idx, last, nxt, done_id_q;
    logic [CW-1:0]   bit_cnt;
    logic [HW-1:0]   hit_cnt, hit_inc, hit_count_q;
    logic            done_q, accept, hit;

    assign nxt     = IW'(rr_next(NREQ_MAX'(bus.req), IDX_W'(last), NREQ));
    assign accept  = (state == STREAM) && bus.bit_valid[idx];
    assign hit_inc = hit_cnt + HW'(hit);

    run4_detector u_det (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == INIT),
        .en    (accept),
        .b     (bus.bit_in[idx]),
        .hit   (hit)
    );

`ifdef RUN_DET_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_cnt;
    logic          abort_pend, abort_q;
    assign bus.abort = abort_q;
`else
    assign bus.abort = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.bit_ready = (state == STREAM) ? gnt_q : '0;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.hit_count = hit_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_q       <= '0;
            idx         <= '0;
            last        <= IW'(NREQ - 1);
            bit_cnt     <= '0;
            hit_cnt     <= '0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            hit_count_q <= '0;
`ifdef RUN_DET_TIMEOUT_EN
            stall_cnt   <= '0;
            abort_pend  <= 1'b0;
            abort_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // z lags the accept by one cycle, so the DRAIN cycle still counts
            if (hit) hit_cnt <= hit_inc;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        idx   <= nxt;
                        gnt_q <= NREQ'(1) << nxt;
                        state <= INIT;
                    end
                end
                INIT: begin
                    hit_cnt <= '0;
                    bit_cnt <= '0;
`ifdef RUN_DET_TIMEOUT_EN
                    stall_cnt  <= '0;
                    abort_pend <= 1'b0;
`endif
                    state   <= STREAM;
                end
                STREAM: begin
                    if (accept) begin
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef RUN_DET_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                        if (bit_cnt == CW'(BURST_LEN - 1)) state <= DRAIN;
                    end
`ifdef RUN_DET_TIMEOUT_EN
                    else if (stall_cnt == SW'(TIMEOUT - 1)) begin
                        abort_pend <= 1'b1;
                        state      <= DRAIN;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    done_q      <= 1'b1;
                    hit_count_q <= hit ? hit_inc : hit_cnt;
                    done_id_q   <= idx;
`ifdef RUN_DET_TIMEOUT_EN
                    abort_q     <= abort_pend;
`endif
                    state       <= REPORT;
                end
                REPORT: begin
                    last  <= idx;
                    gnt_q <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_run_detect_arbiter.sv
// Randomized directed bench for run_detect_arbiter against a run-counting reference model.
module tb_run_detect_arbiter;
    localparam int NREQ = 4;
    localparam int BL   = 16;
`ifdef RUN_DET_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_m = NREQ - 1;
    int   last_acc_cyc, done_cyc;

    always #5 clk = ~clk;

    run_detect_arbiter_if #(.NREQ(NREQ), .HW(5)) bus ();

    run_detect_arbiter #(.NREQ(NREQ), .BURST_LEN(BL), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hits = positions whose bit equals the three preceding accepted bits.
    function automatic int ref_hits(input logic [15:0] p, input int n);
        int c = 0;
        for (int i = 3; i < n; i++)
            if (p[i] == p[i-1] && p[i] == p[i-2] && p[i] == p[i-3]) c++;
        return c;
    endfunction

    function automatic int ref_rr(input logic [3:0] m, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0; bus.bit_valid = '0; bus.bit_in = '0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_ready", 32'(bus.bit_ready), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_hits", 32'(bus.hit_count), 0);
        chk("rst_id", 32'(bus.done_id), 0);
        chk("rst_abort", 32'(bus.abort), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_m = NREQ - 1;
    endtask

    task automatic burst(input logic [3:0] mask, input logic [15:0] pat, input int stall_pct,
                         input int hole_at, input bit drop_req, input int rst_after,
                         input int stop_after);
        int   g, k, cyc, first_rdy, hole, exp_hits;
        bit   seen_done, v;
        logic [1:0] gi;
        g = ref_rr(mask, last_m);
        gi = 2'(g);
        k = 0; cyc = 0; first_rdy = -1; hole = 0; seen_done = 1'b0;
        bus.req = mask;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (rst_after >= 0 && k >= rst_after) begin
                bus.bit_valid = '0;
                do_reset();
                return;
            end
            if ($countones(bus.gnt) > 1) chk("gnt_onehot", 32'($countones(bus.gnt)), 1);
            if (bus.done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                exp_hits  = ref_hits(pat, k);
                chk("done_id", 32'(bus.done_id), 32'(g));
                chk("hit_count", 32'(bus.hit_count), 32'(exp_hits));
                chk("abort", 32'(bus.abort), 32'(TO_EN && stop_after >= 0));
                chk("bits_taken", 32'(k), (TO_EN && stop_after >= 0) ? 32'(stop_after) : BL);
            end else begin
                if (bus.bit_ready != 0 && first_rdy < 0) begin
                    first_rdy = cyc;
                    chk("grant", 32'(bus.gnt), 32'(1) << g);
                    chk("grant_lat", 32'(first_rdy), 2);
                end
                bus.bit_valid = 4'($urandom);
                bus.bit_in    = 4'($urandom);
                v = (k < BL) && !(stop_after >= 0 && k >= stop_after)
                    && ($urandom_range(99) >= stall_pct);
                if (k == hole_at && hole < 10) begin v = 1'b0; hole++; end
                bus.bit_valid[gi] = v;
                bus.bit_in[gi]    = (k < BL) ? pat[k] : 1'b0;
                if (v && bus.bit_ready[gi]) begin k++; last_acc_cyc = cyc; end
                if (drop_req && k == 4) bus.req = '0;
            end
        end
        if (!seen_done) begin
            chk("done_seen", 0, 1);
            return;
        end
        last_m = g;
        bus.bit_valid = '0;
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("gnt_release", 32'(bus.gnt), 0);
        chk("hit_hold", 32'(bus.hit_count), 32'(exp_hits));
    endtask

    initial begin
        logic [15:0] p1;
        logic [3:0]  m;
        p1 = 16'b0000_0011_1110_0000;
        bus.req = '0; bus.bit_valid = '0; bus.bit_in = '0;
        do_reset();

        burst(4'b0001, p1, 0, -1, 1'b0, -1, -1);
        chk("p1_hits", 32'(bus.hit_count), 7);
        burst(4'b0010, 16'h5555, 0, -1, 1'b0, -1, -1);
        chk("alt_hits", 32'(bus.hit_count), 0);
        burst(4'b0010, 16'hFFFF, 0, -1, 1'b0, -1, -1);
        chk("ones_hits", 32'(bus.hit_count), 13);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            burst(4'b1111, 16'($urandom), 30, -1, 1'b0, -1, -1);
            chk("rr_order", 32'(bus.done_id), 32'(i));
        end

        burst(4'b0001, p1, 0, 7, 1'b0, -1, -1);
        chk("stall_hits", 32'(bus.hit_count), 7);

        burst(4'b0001, 16'hFFFF, 0, -1, 1'b0, 8, -1);
        burst(4'b1111, 16'b0101_0101_0101_0111, 0, -1, 1'b0, -1, -1);
        chk("post_rst_id", 32'(bus.done_id), 0);
        chk("post_rst_hits", 32'(bus.hit_count), 0);

        for (int i = 0; i < 20; i++) begin
            m = 4'($urandom_range(15, 1));
            burst(m, 16'($urandom) | ((i % 3 == 0) ? 16'hF0F0 : 16'h0), $urandom_range(40),
                  -1, 1'($urandom), -1, -1);
        end

`ifdef RUN_DET_TIMEOUT_EN
        do_reset();
        burst(4'b0001, 16'hFFFF, 0, -1, 1'b0, -1, 6);
        chk("to_hits", 32'(bus.hit_count), 3);
        chk("to_abort", 32'(bus.abort), 1);
        chk("to_latency", 32'(done_cyc - last_acc_cyc), 66);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/run_detect_arbiter.md
Name: run_detect_arbiter

Overview:
Shares one run-of-four serial detector between NREQ bit-stream requesters. Grants are round-robin. For each grant the block clears the detector context, streams exactly BURST_LEN bits from the granted requester and counts detector hits. It then reports the count with a one-cycle done pulse. It sits between the serial bit sources and the result consumer, and owns sequencing of the detector datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
BURST_LEN, 16, bits streamed per grant (>=4)
HW, $clog2(BURST_LEN+1), width of hit_count
TIMEOUT, 64, maximum consecutive stall cycles while streaming (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  request per requester, level
gnt  output  NREQ  one-hot grant, held from INIT through REPORT
bit_in  input  NREQ  serial data per requester
bit_valid  input  NREQ  data-valid per requester
bit_ready  output  NREQ  gnt[i] & (state==STREAM); a bit is accepted when bit_valid[i] & bit_ready[i]
done  output  1  one-cycle pulse in REPORT
done_id  output  $clog2(NREQ)  index of the reported requester, valid with done
hit_count  output  HW  hits in the finished burst, valid with done
abort  output  1  burst ended by timeout, valid with done; constant 0 without the optional feature

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; gnt, bit_ready, done, done_id, hit_count and abort are all 0.
  - Round-robin pointer last=NREQ-1, so req[0] has first priority.
  - Detector context cleared (prev-bit reg, first flag=1, q0=0, q1=0, z=0).
- FSM: IDLE -> INIT -> STREAM -> DRAIN -> REPORT -> IDLE.
- IDLE: if any req bit is set, choose the first set bit searching from last+1 with wrap-around, latch its index, set gnt, go to INIT. A req that drops before the grant is simply not chosen.
- INIT (1 cycle): detector context cleared as at reset; hit counter=0; bit counter=0.
- STREAM:
  - Each accepted bit advances the detector once and increments the bit counter.
  - Cycles with no accepted bit hold all detector state.
  - After the BURST_LEN-th accepted bit, go to DRAIN.
- Detector (advances only on accept, bit b):
  - a = first ? 0 : (b == prev); the first flag clears on the first accept; prev <= b.
  - q0 <= a; q1 <= a & q0; z <= a & q1. z is registered and is 0 on non-accept cycles.
  - Result: z pulses the cycle after any accepted bit that completes four identical consecutive bits. Runs overlap, so a run of length L yields L-3 hits.
- Hit counter: increments in any cycle with z=1, including the DRAIN cycle. This captures the final bit's hit. Maximum value is BURST_LEN-3, so it never saturates.
- DRAIN (1 cycle): no accepts; count the last z; go to REPORT.
- REPORT (1 cycle): done=1 with hit_count, done_id and abort; last <= granted index; gnt deasserts at the next edge; go to IDLE.
- Outputs hit_count, done_id and abort hold their value until the next REPORT.
- Minimum re-grant gap: one IDLE cycle after REPORT.
- req deasserting mid-burst is ignored; the burst completes. bit_valid on non-granted requesters is ignored.
- Reset asserted mid-burst: immediate abandonment; no done pulse.

Optional Feature:
RUN_DET_TIMEOUT_EN:
- Defined: a stall counter in STREAM counts consecutive cycles without an accept and clears on each accept. When it reaches TIMEOUT, go to DRAIN with the abort flag set. REPORT then gives abort=1 and the partial hit_count.
- Undefined: no stall counter; STREAM waits indefinitely; abort is tied to 0.

Decomposition:
- Package run_detect_pkg:
  - state enum (IDLE, INIT, STREAM, DRAIN, REPORT)
  - function for the round-robin next-index search
  - localparam for the requester index width
- Sub-module run4_detector holds the detector:
  - clk, rst_n
  - clear: synchronous context clear
  - en: accept strobe
  - b: bit in
  - hit: registered z
- The arbiter FSM, counters and output registers stay in the top.

Test Plan:
- req[0] only, continuous valid, bits 0000_0111_1100_0000 (b0 first) -> one done pulse, done_id=0, hit_count=7, abort=0; first accept 2 cycles after req.
- req[1] only, alternating 0101... -> hit_count=0. All-ones burst -> hit_count=13.
- req=4'b1111 held for 4 bursts -> grant order 0,1,2,3 and done_id sequence 0,1,2,3; exactly one gnt bit set at any time.
- Granted requester drops bit_valid for 10 cycles mid-burst -> detector state held; hit_count equals the unstalled result (7 for the first pattern).
- rst_n pulsed low during STREAM -> all outputs 0 immediately; next grant goes to req[0] with a clean context and no stale hits.
- With RUN_DET_TIMEOUT_EN, TIMEOUT=64, valid stopped after 6 bits of all-ones -> done after 64 idle cycles plus DRAIN, abort=1, hit_count=3.
